// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: symbolic op + fields -> 32-bit word, two-stage valid/ready pipeline.
// Optional statistics counters (enc_count/err_count) are enabled by defining RV_ENC_STATS_EN.
module rv_instr_encoder
`ifdef RV_ENC_STATS_EN
  #(parameter int unsigned CNT_W = 16)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
`ifdef RV_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [5:0] {
    OP_BEQ  = 6'd0,  OP_BNE   = 6'd1,  OP_BLT   = 6'd2,  OP_BGE  = 6'd3,
    OP_BLTU = 6'd4,  OP_BGEU  = 6'd5,  OP_ADD   = 6'd6,  OP_ADDI = 6'd7,
    OP_SLTI = 6'd8,  OP_OR    = 6'd9,  OP_ORI   = 6'd10, OP_XOR  = 6'd11,
    OP_XORI = 6'd12, OP_AND   = 6'd13, OP_ANDI  = 6'd14, OP_SUB  = 6'd15,
    OP_SLTIU= 6'd16, OP_SLLI  = 6'd17, OP_SRLI  = 6'd18, OP_SRAI = 6'd19,
    OP_SLL  = 6'd20, OP_SLT   = 6'd21, OP_SLTU  = 6'd22, OP_SRL  = 6'd23,
    OP_SRA  = 6'd24, OP_LUI   = 6'd25, OP_AUIPC = 6'd26, OP_JAL  = 6'd27,
    OP_JALR = 6'd28, OP_LB    = 6'd29, OP_LH    = 6'd30, OP_LW   = 6'd31,
    OP_LBU  = 6'd32, OP_LHU   = 6'd33, OP_SB    = 6'd34, OP_SH   = 6'd35,
    OP_SW   = 6'd36, OP_ECALL = 6'd37
  } op_e;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_ILL
  } fmt_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic        r_s1_valid;
  logic [5:0]  r_s1_op;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [31:0] r_s1_imm;

  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;

  fmt_e        w_fmt;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_imm_ok;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_out_xfer;
  logic        w_s2_load;

  assign w_out_xfer = r_s2_valid && out_ready;
  assign w_s2_load  = !r_s2_valid || w_out_xfer;
  // S1 may refill in the same cycle it hands its request to S2.
  assign in_ready   = !r_s1_valid || w_s2_load;

  assign out_valid  = r_s2_valid;
  assign out_instr  = r_s2_instr;
  assign out_err    = r_s2_err;

  always_comb begin
    w_fmt = FMT_ILL;
    w_opc = '0;
    w_f3  = '0;
    w_f7  = '0;
    case (op_e'(r_s1_op))
      OP_BEQ:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b000; end
      OP_BNE:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b001; end
      OP_BLT:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b100; end
      OP_BGE:   begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b101; end
      OP_BLTU:  begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b110; end
      OP_BGEU:  begin w_fmt = FMT_B;  w_opc = OPC_BRANCH; w_f3 = 3'b111; end
      OP_ADD:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b000; end
      OP_SUB:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b000; w_f7 = F7_ALT; end
      OP_SLL:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b001; end
      OP_SLT:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b010; end
      OP_SLTU:  begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b011; end
      OP_XOR:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b100; end
      OP_SRL:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b101; end
      OP_SRA:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b101; w_f7 = F7_ALT; end
      OP_OR:    begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b110; end
      OP_AND:   begin w_fmt = FMT_R;  w_opc = OPC_OP;     w_f3 = 3'b111; end
      OP_ADDI:  begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b000; end
      OP_SLTI:  begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b010; end
      OP_SLTIU: begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b011; end
      OP_XORI:  begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b100; end
      OP_ORI:   begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b110; end
      OP_ANDI:  begin w_fmt = FMT_I;  w_opc = OPC_OPIMM;  w_f3 = 3'b111; end
      OP_SLLI:  begin w_fmt = FMT_SH; w_opc = OPC_OPIMM;  w_f3 = 3'b001; end
      OP_SRLI:  begin w_fmt = FMT_SH; w_opc = OPC_OPIMM;  w_f3 = 3'b101; end
      OP_SRAI:  begin w_fmt = FMT_SH; w_opc = OPC_OPIMM;  w_f3 = 3'b101; w_f7 = F7_ALT; end
      OP_LUI:   begin w_fmt = FMT_U;  w_opc = OPC_LUI;    end
      OP_AUIPC: begin w_fmt = FMT_U;  w_opc = OPC_AUIPC;  end
      OP_JAL:   begin w_fmt = FMT_J;  w_opc = OPC_JAL;    end
      OP_JALR:  begin w_fmt = FMT_I;  w_opc = OPC_JALR;   w_f3 = 3'b000; end
      OP_LB:    begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = 3'b000; end
      OP_LH:    begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = 3'b001; end
      OP_LW:    begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = 3'b010; end
      OP_LBU:   begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = 3'b100; end
      OP_LHU:   begin w_fmt = FMT_I;  w_opc = OPC_LOAD;   w_f3 = 3'b101; end
      OP_SB:    begin w_fmt = FMT_S;  w_opc = OPC_STORE;  w_f3 = 3'b000; end
      OP_SH:    begin w_fmt = FMT_S;  w_opc = OPC_STORE;  w_f3 = 3'b001; end
      OP_SW:    begin w_fmt = FMT_S;  w_opc = OPC_STORE;  w_f3 = 3'b010; end
      OP_ECALL: begin w_fmt = FMT_SYS; end
      default:  begin w_fmt = FMT_ILL; end
    endcase
  end

  // Range checks reduce to "upper bits are a pure sign extension" plus alignment.
  always_comb begin
    w_imm_ok = 1'b1;
    case (w_fmt)
      FMT_I, FMT_S: w_imm_ok = (r_s1_imm[31:11] == '0) || (r_s1_imm[31:11] == '1);
      FMT_SH:       w_imm_ok = (r_s1_imm[31:5] == '0);
      FMT_B:        w_imm_ok = ((r_s1_imm[31:12] == '0) || (r_s1_imm[31:12] == '1)) && !r_s1_imm[0];
      FMT_J:        w_imm_ok = ((r_s1_imm[31:20] == '0) || (r_s1_imm[31:20] == '1)) && !r_s1_imm[0];
      FMT_U:        w_imm_ok = (r_s1_imm[11:0] == '0);
      default:      w_imm_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_instr = '0;
    case (w_fmt)
      FMT_R:   w_instr = {w_f7, r_s1_rs2, r_s1_rs1, w_f3, r_s1_rd, w_opc};
      FMT_I:   w_instr = {r_s1_imm[11:0], r_s1_rs1, w_f3, r_s1_rd, w_opc};
      FMT_SH:  w_instr = {w_f7, r_s1_imm[4:0], r_s1_rs1, w_f3, r_s1_rd, w_opc};
      FMT_S:   w_instr = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, w_f3, r_s1_imm[4:0], w_opc};
      FMT_B:   w_instr = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, w_f3,
                          r_s1_imm[4:1], r_s1_imm[11], w_opc};
      FMT_U:   w_instr = {r_s1_imm[31:12], r_s1_rd, w_opc};
      FMT_J:   w_instr = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                          r_s1_rd, w_opc};
      FMT_SYS: w_instr = 32'h0000_0073;
      default: w_instr = '0;
    endcase
  end

  assign w_err = (w_fmt == FMT_ILL) || !w_imm_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_instr;
          r_s2_err   <= w_err;
        end
      end
    end
  end

  // NOTE: S1 payload has no reset; r_s1_valid alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1_op  <= op;
      r_s1_rd  <= rd;
      r_s1_rs1 <= rs1;
      r_s1_rs2 <= rs2;
      r_s1_imm <= imm;
    end
  end

`ifdef RV_ENC_STATS_EN
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_out_xfer) begin
      if (r_enc_count != '1) r_enc_count <= r_enc_count + 1'b1;
      if (r_s2_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign enc_count = r_enc_count;
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: driver pushes expected words, monitor pops on out transfers.
module tb_rv_instr_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
`ifdef RV_ENC_STATS_EN
  logic [15:0] enc_count;
  logic [15:0] err_count;
`endif

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  rv_instr_encoder u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
`ifdef RV_ENC_STATS_EN
    ,
    .enc_count (enc_count),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask

  // Monitor: sample just before the rising edge, where the transfer is decided.
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_pop++;
        check("sb_instr", out_instr, e.instr);
        check("sb_err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic push(input logic [31:0] ei, input logic ee);
    exp_t e;
    e.instr = ei;
    e.err   = ee;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Offers one request and returns right after the edge that accepts it.
  task automatic send(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] ei, input logic ee);
    bit done = 1'b0;
    @(negedge clk);
    drive(o, d, s1, s2, im);
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (in_ready) begin
        push(ei, ee);
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) fail("send_accept");
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      #6;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) fail("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [5:0]  bp_op  [3];
    logic [4:0]  bp_rd  [3];
    logic [4:0]  bp_rs1 [3];
    logic [4:0]  bp_rs2 [3];
    logic [31:0] bp_imm [3];
    logic [31:0] bp_exp [3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5 with latency check
    send(6'd7, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // add then sub on consecutive cycles
    send(6'd6,  5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    send(6'd15, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    check("b2b_first", out_instr, 32'h0020_81B3);
    @(negedge clk); #1;
    check("b2b_second", out_instr, 32'h4020_81B3);
    drain();

    // formats
    send(6'd0,  5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0); // beq x1,x2,+8
    send(6'd25, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0); // lui x5
    send(6'd19, 5'd4, 5'd4, 5'd0, 32'd3,          32'h4032_5213, 1'b0); // srai x4,x4,3
    send(6'd37, 5'd5, 5'd7, 5'd9, 32'd123,        32'h0000_0073, 1'b0); // ecall, junk fields
    send(6'd36, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC,  32'hFE51_2E23, 1'b0); // sw x5,-4(x2)
    send(6'd27, 5'd1, 5'd0, 5'd0, 32'd16,         32'h0100_00EF, 1'b0); // jal x1,16
    drain();

    // error cases
    send(6'd7,  5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b1); // addi imm out of range
    send(6'd0,  5'd0, 5'd1, 5'd2, 32'd3,    32'h0020_8163, 1'b1); // beq odd offset
    send(6'd50, 5'd1, 5'd1, 5'd1, 32'd0,    32'h0000_0000, 1'b1); // illegal op
    drain();
`ifdef RV_ENC_STATS_EN
    check("stats_err_count", {16'd0, err_count}, 32'd3);
    check("stats_enc_count", {16'd0, enc_count}, 32'd12);
`endif
    send(6'd7,  5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0); // addi -2048 is legal
    send(6'd17, 5'd1, 5'd1, 5'd0, 32'd32,        32'h0000_9093, 1'b1); // slli shamt 32
    drain();

    // backpressure: three requests, only two fit
    bp_op[0] = 6'd31; bp_rd[0] = 5'd6; bp_rs1[0] = 5'd7; bp_rs2[0] = 5'd0; bp_imm[0] = 32'd8; bp_exp[0] = 32'h0083_A303;
    bp_op[1] = 6'd11; bp_rd[1] = 5'd5; bp_rs1[1] = 5'd6; bp_rs2[1] = 5'd7; bp_imm[1] = 32'd0; bp_exp[1] = 32'h0073_42B3;
    bp_op[2] = 6'd28; bp_rd[2] = 5'd0; bp_rs1[2] = 5'd1; bp_rs2[2] = 5'd0; bp_imm[2] = 32'd0; bp_exp[2] = 32'h0000_8067;
    accepted = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      drive(bp_op[accepted], bp_rd[accepted], bp_rs1[accepted], bp_rs2[accepted], bp_imm[accepted]);
      #1;
      if (in_ready && accepted < 3) begin
        push(bp_exp[accepted], 1'b0);
        accepted++;
      end
    end
    check("bp_accepted", accepted, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_stable", out_instr, 32'h0083_A303);
    @(negedge clk);
    out_ready = 1'b1;
    drive(bp_op[2], bp_rd[2], bp_rs1[2], bp_rs2[2], bp_imm[2]);
    #1;
    if (in_ready) push(bp_exp[2], 1'b0);
    else fail("bp_release_accept");
    @(posedge clk);
    drain();

    // reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    send(6'd11, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0073_42B3, 1'b0);
    send(6'd28, 5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_8067, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_instr", out_instr, 32'd0);
    n_push -= exp_q.size();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(6'd7, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    check("postrst_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("postrst_cycle2_valid", {31'd0, out_valid}, 32'd1);
    drain();

    check("pop_count", n_pop, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
